// File: rtl/syscon_seq.sv
// rtl/syscon_seq.sv - staggered reset-domain sequencer with enable, slow tick and soft reset.
// Optional watchdog auto-reset is compiled in when WATCHDOG_EN is defined.
module syscon_seq #(
  parameter int N_CH        = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int TICK_DIV    = 12,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            soft_rst_req,
  input  logic            wdt_kick,
  output logic [N_CH-1:0] rst_out,
  output logic            enable,
  output logic            tick,
  output logic [1:0]      reset_cause
);

  localparam int SEQ_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int TICK_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [SEQ_W-1:0]  SEQ_ONE      = SEQ_W'(1);
  localparam logic [SEQ_W-1:0]  HOLD_LAST    = SEQ_W'(HOLD_CYCLES);
  localparam logic [SEQ_W-1:0]  STAGGER_LAST = SEQ_W'(STAGGER - 1);
  localparam logic [TICK_W-1:0] TICK_ONE     = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t            state, state_n;
  logic [SEQ_W-1:0]  seq_cnt, seq_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [N_CH-1:0]   rst_out_n;
  logic              enable_n, tick_n;
  logic [1:0]        cause_n;
  logic              wdt_fire;

`ifdef WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES);
  localparam logic [WDT_W-1:0] WDT_ONE  = WDT_W'(1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt, wdt_n;

  always_comb begin
    wdt_n    = wdt_cnt;
    wdt_fire = 1'b0;
    if (state != RUN || soft_rst_req) begin
      wdt_n = '0;
    end else if (wdt_kick) begin
      wdt_n = '0;
    end else if (wdt_cnt == WDT_LAST) begin
      wdt_fire = 1'b1;
      wdt_n    = '0;
    end else begin
      wdt_n = wdt_cnt + WDT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wdt_cnt <= '0;
    else     wdt_cnt <= wdt_n;
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES > 1);
  assign wdt_fire   = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    seq_n      = seq_cnt;
    tick_cnt_n = tick_cnt;
    rst_out_n  = rst_out;
    enable_n   = enable;
    tick_n     = 1'b0;
    cause_n    = reset_cause;
    if (soft_rst_req || wdt_fire) begin
      // The restart edge itself is the first hold cycle, so offsets match a cold start.
      state_n    = HOLD;
      seq_n      = SEQ_ONE;
      tick_cnt_n = '0;
      rst_out_n  = '1;
      enable_n   = 1'b0;
      cause_n    = soft_rst_req ? 2'd1 : 2'd2;
    end else begin
      case (state)
        HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            rst_out_n = rst_out << 1;
            seq_n     = '0;
            state_n   = RELEASE;
          end else begin
            seq_n = seq_cnt + SEQ_ONE;
          end
        end
        RELEASE: begin
          if (!rst_out[N_CH-1]) begin
            enable_n = 1'b1;
            state_n  = RUN;
          end else if (seq_cnt == STAGGER_LAST) begin
            rst_out_n = rst_out << 1;
            seq_n     = '0;
          end else begin
            seq_n = seq_cnt + SEQ_ONE;
          end
        end
        RUN: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            tick_n     = 1'b1;
          end else begin
            tick_cnt_n = tick_cnt + TICK_ONE;
          end
        end
        default: state_n = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      seq_cnt     <= '0;
      tick_cnt    <= '0;
      rst_out     <= '1;
      enable      <= 1'b0;
      tick        <= 1'b0;
      reset_cause <= 2'd0;
    end else begin
      state       <= state_n;
      seq_cnt     <= seq_n;
      tick_cnt    <= tick_cnt_n;
      rst_out     <= rst_out_n;
      enable      <= enable_n;
      tick        <= tick_n;
      reset_cause <= cause_n;
    end
  end

endmodule

// File: tb/tb_syscon_seq.sv
// tb/tb_syscon_seq.sv - vector table, reference-model and watchdog sequences for syscon_seq.
module tb_syscon_seq;
  localparam int N_CH = 4;
  localparam int HOLD = 16;
  localparam int STAG = 4;
  localparam int TDIV = 12;
  localparam int WDT  = 64;
  localparam int NEVER = -1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rst_req = 1'b0;
  logic wdt_kick = 1'b0;
  logic [N_CH-1:0] rst_out;
  logic enable, tick;
  logic [1:0] reset_cause;

  int checks = 0;
  int errors = 0;

  syscon_seq #(.N_CH(N_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAG), .TICK_DIV(TDIV),
               .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .wdt_kick(wdt_kick),
    .rst_out(rst_out), .enable(enable), .tick(tick), .reset_cause(reset_cause)
  );

  always #5 clk = ~clk;

  // Reference model: everything is derived from the edge index where the current sequence started.
  int cyc = 0;
  int start = 0;
  int last_kick = NEVER;
  int m_cause = 0;
  bit in_rst = 1'b1;
  logic [N_CH-1:0] m_rst_out;
  logic m_en, m_tick;

  function automatic int en_edge();
    return start + HOLD + (N_CH - 1) * STAG + 1;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit k);
    bit fire;
`ifdef WATCHDOG_EN
    int ref_e;
`endif
    cyc++;
    fire = 1'b0;
    if (r) begin
      in_rst  = 1'b1;
      m_cause = 0;
    end else begin
      if (in_rst) begin
        in_rst    = 1'b0;
        start     = cyc;
        last_kick = NEVER;
      end
`ifdef WATCHDOG_EN
      ref_e = (last_kick > en_edge()) ? last_kick : en_edge();
      fire  = (cyc > en_edge()) && !k && (cyc - ref_e == WDT);
`endif
      if (s || fire) begin
        start     = cyc;
        m_cause   = s ? 1 : 2;
        last_kick = NEVER;
      end else if (k && cyc > en_edge()) begin
        last_kick = cyc;
      end
    end
    if (in_rst) begin
      m_rst_out = '1;
      m_en      = 1'b0;
      m_tick    = 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) m_rst_out[i] = (cyc - start) < (HOLD + i * STAG);
      m_en   = cyc >= en_edge();
      m_tick = (cyc > en_edge()) && ((cyc - en_edge()) % TDIV == 0);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit k);
    rst = r;
    soft_rst_req = s;
    wdt_kick = k;
    @(posedge clk);
    model_edge(r, s, k);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit              r;
    bit              s;
    bit              k;
    int              n;
    logic [N_CH-1:0] ro;
    logic            en;
    logic            tk;
    logic [1:0]      cause;
  } vec_t;

  vec_t vecs[24];
  int drops;

  initial begin
    vecs[0]  = '{1, 0, 0, 5,  4'b1111, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1,  4'b1111, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 15, 4'b1111, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1,  4'b1110, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 3,  4'b1110, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 1,  4'b1100, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 4,  4'b1000, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 4,  4'b0000, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 1,  4'b0000, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 11, 4'b0000, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 1,  4'b0000, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 1,  4'b0000, 1, 0, 0};
    vecs[12] = '{0, 0, 0, 10, 4'b0000, 1, 0, 0};
    vecs[13] = '{0, 0, 0, 1,  4'b0000, 1, 1, 0};
    vecs[14] = '{0, 1, 0, 1,  4'b1111, 0, 0, 1};
    vecs[15] = '{0, 0, 0, 15, 4'b1111, 0, 0, 1};
    vecs[16] = '{0, 0, 0, 1,  4'b1110, 0, 0, 1};
    vecs[17] = '{0, 0, 0, 6,  4'b1100, 0, 0, 1};
    vecs[18] = '{0, 1, 0, 1,  4'b1111, 0, 0, 1};
    vecs[19] = '{0, 0, 0, 16, 4'b1110, 0, 0, 1};
    vecs[20] = '{0, 0, 0, 13, 4'b0000, 1, 0, 1};
    vecs[21] = '{1, 1, 0, 1,  4'b1111, 0, 0, 0};
    vecs[22] = '{0, 0, 0, 29, 4'b0000, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 1,  4'b0000, 1, 0, 0};

    for (int v = 0; v < 24; v++) begin
      for (int c = 0; c < vecs[v].n; c++) step(vecs[v].r, vecs[v].s, vecs[v].k);
      check($sformatf("vec%0d_rst_out", v), rst_out, vecs[v].ro);
      check($sformatf("vec%0d_enable", v), enable, vecs[v].en);
      check($sformatf("vec%0d_tick", v), tick, vecs[v].tk);
      check($sformatf("vec%0d_cause", v), reset_cause, vecs[v].cause);
    end

    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0);
      check("random_outputs", {rst_out, enable, tick, reset_cause},
            {m_rst_out, m_en, m_tick, m_cause[1:0]});
    end

    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    check("wdt_run_entry", enable, 1);
    for (int i = 0; i < 63; i++) step(0, 0, 0);
    check("wdt_before_timeout", enable, 1);
    step(0, 0, 0);
`ifdef WATCHDOG_EN
    check("wdt_timeout_rst_out", rst_out, 4'b1111);
    check("wdt_timeout_enable", enable, 0);
    check("wdt_timeout_cause", reset_cause, 2);
`else
    check("no_wdt_rst_out", rst_out, 4'b0000);
    check("no_wdt_enable", enable, 1);
    check("no_wdt_cause", reset_cause, 0);
`endif

    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0);
    drops = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 0, (i % 50) == 49);
      if (enable !== 1'b1) drops++;
    end
    check("kicked_enable_drops", drops, 0);
    check("kicked_cause", reset_cause, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
